renkon_linebuf: RTL

- Upstream neighbour of the renkon datapath (conv → bias → relu → pool).
- Accepts a raster-ordered stream of input feature pixels, one per accepted cycle, and buffers the last 4 image lines.
- Presents a 5x5 sliding window on pixel0..pixel24 to the conv stage, plus a per-window valid strobe that the controller turns into conv_oe / mem_feat_we.

---
 rtl/renkon_linebuf_if.sv | 37 +++
 rtl/renkon_linebuf.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/renkon_linebuf_if.sv
// Pixel-stream-in / 5x5-window-out bundle between the renkon controller and renkon_linebuf.
// master = controller side (drives the stream), slave = line buffer side.
interface renkon_linebuf_if #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10
);
  logic [LWIDTH-1:0]        img_size;
  logic                     buf_en;
  logic signed [DWIDTH-1:0] pixel_in;
  logic signed [DWIDTH-1:0] pixel0,  pixel1,  pixel2,  pixel3,  pixel4;
  logic signed [DWIDTH-1:0] pixel5,  pixel6,  pixel7,  pixel8,  pixel9;
  logic signed [DWIDTH-1:0] pixel10, pixel11, pixel12, pixel13, pixel14;
  logic signed [DWIDTH-1:0] pixel15, pixel16, pixel17, pixel18, pixel19;
  logic signed [DWIDTH-1:0] pixel20, pixel21, pixel22, pixel23, pixel24;
  logic                     win_valid;
  logic                     frame_end;

  modport master (
    output img_size, buf_en, pixel_in,
    input  pixel0,  pixel1,  pixel2,  pixel3,  pixel4,
    input  pixel5,  pixel6,  pixel7,  pixel8,  pixel9,
    input  pixel10, pixel11, pixel12, pixel13, pixel14,
    input  pixel15, pixel16, pixel17, pixel18, pixel19,
    input  pixel20, pixel21, pixel22, pixel23, pixel24,
    input  win_valid, frame_end
  );

  modport slave (
    input  img_size, buf_en, pixel_in,
    output pixel0,  pixel1,  pixel2,  pixel3,  pixel4,
    output pixel5,  pixel6,  pixel7,  pixel8,  pixel9,
    output pixel10, pixel11, pixel12, pixel13, pixel14,
    output pixel15, pixel16, pixel17, pixel18, pixel19,
    output pixel20, pixel21, pixel22, pixel23, pixel24,
    output win_valid, frame_end
  );
endinterface

// File: rtl/renkon_linebuf.sv
// Four-line buffer and 5x5 sliding window in front of the renkon conv stage.
// Build option RENKON_LINEBUF_ZERO_PAD_EN: zero-padded "same" window stream with end-of-frame flush.
module renkon_linebuf #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10,
  parameter int MAXW   = 32,
  parameter int FSIZE  = 5
) (
  input  logic            clk,
  input  logic            xrst,
  renkon_linebuf_if.slave bus
);

  localparam int AW    = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int NTAP  = FSIZE * FSIZE;
  localparam int NLINE = FSIZE - 1;

  logic [LWIDTH-1:0]        col_reg, col_next;
  logic [LWIDTH-1:0]        row_reg, row_next;
  logic [LWIDTH-1:0]        size_reg, size_next;
  logic [LWIDTH-1:0]        size_cur;
  logic                     last_col, last_row;
  logic                     advance;
  logic                     wrap_frame;
  logic signed [DWIDTH-1:0] px_push;
  logic                     win_valid_reg, win_valid_next;
  logic                     frame_end_reg, frame_end_next;

  logic [NLINE*DWIDTH-1:0]  line_mem [MAXW];
  logic [NLINE*DWIDTH-1:0]  line_rd_reg;
  logic [AW-1:0]            rd_addr;
  logic                     mem_we;

  logic signed [DWIDTH-1:0] new_col  [FSIZE];
  logic signed [DWIDTH-1:0] win_reg  [NTAP];
  logic signed [DWIDTH-1:0] win_next [NTAP];
  logic signed [DWIDTH-1:0] tap      [NTAP];

  // The size in force for this pixel: a frame's first pixel takes img_size live.
  assign size_cur = (col_reg == '0 && row_reg == '0) ? bus.img_size : size_reg;
  assign last_col = (col_reg == size_cur - 1'b1);
  assign last_row = (row_reg == size_cur - 1'b1);

  always_comb begin
    col_next  = col_reg;
    row_next  = row_reg;
    size_next = size_reg;
    if (advance) begin
      size_next = size_cur;
      if (wrap_frame) begin
        col_next = '0;
        row_next = '0;
      end else if (last_col) begin
        col_next = '0;
        row_next = row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      col_reg       <= '0;
      row_reg       <= '0;
      size_reg      <= '0;
      win_valid_reg <= 1'b0;
      frame_end_reg <= 1'b0;
    end else begin
      col_reg       <= col_next;
      row_reg       <= row_next;
      size_reg      <= size_next;
      win_valid_reg <= win_valid_next;
      frame_end_reg <= frame_end_next;
    end
  end

  // Line memory is read one cycle ahead at the next column so the registered
  // read already holds L3..L0[col] when that column's pixel is accepted.
  assign mem_we  = advance && !xrst;
  assign rd_addr = xrst ? '0 : col_next[AW-1:0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      line_mem[col_reg[AW-1:0]] <= {line_rd_reg[(NLINE-1)*DWIDTH-1:0], px_push};
    end
    line_rd_reg <= line_mem[rd_addr];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLINE; gi++) begin : g_new_col
      assign new_col[gi] = line_rd_reg[(NLINE-gi)*DWIDTH-1 -: DWIDTH];
    end
    assign new_col[NLINE] = px_push;

    for (gi = 0; gi < NTAP; gi++) begin : g_shift
      if ((gi % FSIZE) == FSIZE - 1) begin : g_in
        assign win_next[gi] = new_col[gi / FSIZE];
      end else begin : g_mv
        assign win_next[gi] = win_reg[gi + 1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < NTAP; i++) win_reg[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < NTAP; i++) win_reg[i] <= win_next[i];
    end
  end

`ifdef RENKON_LINEBUF_ZERO_PAD_EN
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                   state_reg, state_next;
  logic                     flush_last;
  logic                     col_lo;
  logic                     emit;
  logic [FSIZE-1:0]         row_ok, col_ok;
  logic signed [DWIDTH-1:0] tap_mask [NTAP];
  logic signed [DWIDTH-1:0] tap_reg  [NTAP];

  // Flush continues the raster with zero pixels through rows size..size+1 and
  // two columns of row size+2, which lets the last 2*size+2 centres complete.
  assign flush_last = (row_reg >= size_reg + LWIDTH'(2)) &&
                      ((col_reg == LWIDTH'(1)) || last_col);

  always_ff @(posedge clk) begin
    if (xrst) state_reg <= ST_RUN;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    advance        = bus.buf_en;
    px_push        = bus.pixel_in;
    wrap_frame     = 1'b0;
    frame_end_next = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (advance && last_col && last_row) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        advance = 1'b1;
        px_push = '0;
        if (flush_last) begin
          wrap_frame     = 1'b1;
          frame_end_next = 1'b1;
          state_next     = ST_RUN;
        end
      end
    endcase
  end

  // Window centre lags the raster position by 2 rows + 2 pixels; at col 0/1
  // the window still holds the previous row's tail, one row higher.
  assign col_lo         = (col_reg < LWIDTH'(2));
  assign emit           = advance && ((row_reg > LWIDTH'(2)) ||
                                      ((row_reg == LWIDTH'(2)) && !col_lo));
  assign win_valid_next = emit;

  generate
    for (gi = 0; gi < FSIZE; gi++) begin : g_mask
      assign row_ok[gi] = (row_reg + LWIDTH'(gi)) >=
                          (col_lo ? LWIDTH'(FSIZE) : LWIDTH'(NLINE));
      assign col_ok[gi] = col_lo ? ((col_reg + LWIDTH'(gi)) <  LWIDTH'(NLINE))
                                 : ((col_reg + LWIDTH'(gi)) >= LWIDTH'(NLINE));
    end
    for (gi = 0; gi < NTAP; gi++) begin : g_tap
      assign tap_mask[gi] = (row_ok[gi / FSIZE] && col_ok[gi % FSIZE]) ? win_next[gi] : '0;
      assign tap[gi]      = tap_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < NTAP; i++) tap_reg[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < NTAP; i++) tap_reg[i] <= tap_mask[i];
    end
  end
`else
  assign advance    = bus.buf_en;
  assign px_push    = bus.pixel_in;
  assign wrap_frame = last_col && last_row;

  // Only fully in-image windows: the newest pixel must be at row>=4 and col>=4.
  assign win_valid_next = advance && (row_reg >= LWIDTH'(NLINE)) && (col_reg >= LWIDTH'(NLINE));
  assign frame_end_next = advance && wrap_frame;

  generate
    for (gi = 0; gi < NTAP; gi++) begin : g_tap
      assign tap[gi] = win_reg[gi];
    end
  endgenerate
`endif

  assign bus.win_valid = win_valid_reg;
  assign bus.frame_end = frame_end_reg;

  assign bus.pixel0  = tap[0];
  assign bus.pixel1  = tap[1];
  assign bus.pixel2  = tap[2];
  assign bus.pixel3  = tap[3];
  assign bus.pixel4  = tap[4];
  assign bus.pixel5  = tap[5];
  assign bus.pixel6  = tap[6];
  assign bus.pixel7  = tap[7];
  assign bus.pixel8  = tap[8];
  assign bus.pixel9  = tap[9];
  assign bus.pixel10 = tap[10];
  assign bus.pixel11 = tap[11];
  assign bus.pixel12 = tap[12];
  assign bus.pixel13 = tap[13];
  assign bus.pixel14 = tap[14];
  assign bus.pixel15 = tap[15];
  assign bus.pixel16 = tap[16];
  assign bus.pixel17 = tap[17];
  assign bus.pixel18 = tap[18];
  assign bus.pixel19 = tap[19];
  assign bus.pixel20 = tap[20];
  assign bus.pixel21 = tap[21];
  assign bus.pixel22 = tap[22];
  assign bus.pixel23 = tap[23];
  assign bus.pixel24 = tap[24];

endmodule
